maze_tile_map: RTL and testbench
================================

Name: maze_tile_map

Overview:
- Writable, multi-port successor to the static valid-position ROM; holds a 2-bit tile code per maze cell (empty/pellet/power/wall).
- Serves NUM_RD independent synchronous read channels (Pac-Man, ghosts) and one eat port that clears consumed pellets.
- Tracks the remaining pellet count and flags level clear.
- Contains a reload sequencer that restores the level layout after reset or on request.

Parameters:
- ROWS, 24, maze rows.
- COLS, 32, maze columns.
- NUM_RD, 2, number of read channels.
- FRIGHT_CYCLES, 1000, frightened-mode duration in clocks; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_row  in  NUM_RD x $clog2(ROWS)  per-channel row address.
- rd_col  in  NUM_RD x $clog2(COLS)  per-channel column address.
- rd_tile  out  NUM_RD x 2  per-channel tile code.
- eat_valid  in  1  eat request.
- eat_row  in  $clog2(ROWS)  eat row.
- eat_col  in  $clog2(COLS)  eat column.
- eat_pellet  out  1  one-cycle pulse: a pellet was consumed.
- eat_power  out  1  one-cycle pulse: a power pellet was consumed.
- reload_start  in  1  pulse: restart the level layout.
- busy  out  1  reload in progress.
- pellet_count  out  CNT_W = $clog2(ROWS*COLS+1)  remaining pellets plus power pellets.
- level_clear  out  1  high when not busy and pellet_count == 0.
- fright_active  out  1  frightened mode; tied 0 unless the optional feature is compiled in.

Behaviour:
- Tile codes: 2'b00 EMPTY, 2'b01 PELLET, 2'b10 POWER, 2'b11 WALL.
- Reset values:
  - State RELOAD, row index 0, busy=1.
  - pellet_count=0; rd_tile all WALL.
  - eat_pellet, eat_power, level_clear, fright_active all 0.
- States: RELOAD, RUN.
- RELOAD:
  - Writes one full row per cycle from package constant MAZE_INIT.
  - Cells outside the MAZE_INIT extent load as WALL.
  - Accumulates the PELLET+POWER count of each row into pellet_count; pellet_count is cleared on entry.
  - After row ROWS-1 is written, moves to RUN; busy deasserts on the first RUN cycle.
  - Duration is exactly ROWS cycles.
- Entry to RELOAD: on reset release, and from any state on reload_start. reload_start while busy restarts at row 0.
- RUN reads:
  - rd_tile[i] is valid 1 cycle after the address is presented, for all channels independently.
  - An out-of-range row or column returns WALL.
- Reads while busy return WALL.
- Eat, in RUN only:
  - If the addressed tile is PELLET or POWER: the tile becomes EMPTY, pellet_count decrements by 1, and eat_pellet or eat_power pulses for one cycle on the following cycle.
  - If the tile is EMPTY, WALL, or out of range: no effect and no pulse.
- eat_valid while busy is ignored.
- Same-cycle eat and reload_start: reload wins and the eat is dropped.
- Read and eat to the same tile in the same cycle: the read returns the pre-eat value (read-before-write). A read of that tile on the next cycle returns EMPTY.
- pellet_count never underflows; a decrement at 0 is impossible by construction, and the bench asserts this.
- level_clear is registered; it asserts the cycle after pellet_count reaches 0 in RUN, and clears on reload.

Optional Feature:
- Macro: MAZE_FRIGHT_TIMER_EN.
- Defined:
  - Every eat_power pulse loads a down-counter with FRIGHT_CYCLES.
  - fright_active is high while the counter is nonzero.
  - A new power pellet reloads the counter to its full value.
  - Reload or reset clears the counter.
- Undefined: no counter is instantiated; fright_active is a constant 0.

Decomposition:
- Package maze_pkg holds:
  - typedef enum logic [1:0] tile_t {EMPTY, PELLET, POWER, WALL};
  - MAZE_ROWS/MAZE_COLS defaults;
  - the constant array MAZE_INIT [ROWS][COLS] of tile_t;
  - the function count_pellets_row().
- One sub-module, maze_reload_fsm: owns the state, row index, busy, and per-row count accumulation.
- Storage and ports stay in the top module.

Test Plan:
- Reset release, then hold -> busy high for exactly 24 cycles; pellet_count equals the MAZE_INIT total; rd_tile is WALL while busy.
- RUN, read a PELLET tile on ch0 and a WALL tile on ch1 in the same cycle -> next cycle rd_tile = 01 and 11.
- Eat a PELLET tile -> eat_pellet pulses 1 cycle, pellet_count decrements by 1, and a re-read gives 00; eating the same tile again gives no pulse and no count change.
- Eat plus read of the same POWER tile in one cycle -> read returns 10, eat_power pulses; with MAZE_FRIGHT_TIMER_EN and FRIGHT_CYCLES=8, fright_active is high for 8 cycles.
- Eat every pellet -> level_clear asserts one cycle after the last eat; reload_start then gives busy for 24 cycles, restored count, and level_clear=0.
- Further checks:
  - rst_n asserted mid-RELOAD -> outputs return to reset values and reload restarts at row 0.
  - reload_start coincident with eat_valid -> count unchanged and no eat pulse.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and the level layout for the maze tile map.
// Each layout row packs one 2-bit tile code per column, column 0 in the low bits.
package maze_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        PELLET = 2'b01,
        POWER  = 2'b10,
        WALL   = 2'b11
    } tile_t;

    localparam int MAZE_ROWS = 24;
    localparam int MAZE_COLS = 32;

    typedef logic [MAZE_COLS-1:0][1:0] maze_row_t;

    localparam maze_row_t MAZE_INIT [MAZE_ROWS] = '{
        64'hFFFF_FFFF_FFFF_FFFF,
        64'hD555_5555_5555_5557,
        64'hE555_5555_5555_555B,
        64'hD5FF_5555_5555_FF57,
        64'hD555_5555_5555_5557,
        64'hD55F_F500_005F_F557,
        64'hD555_5555_5555_5557,
        64'hD5FF_5555_5555_FF57,
        64'hC000_0000_0000_0003,
        64'hD555_5555_5555_5557,
        64'hD55F_F500_005F_F557,
        64'hD5FF_5555_5555_FF57,
        64'hD555_5555_5555_5557,
        64'hD55F_F500_005F_F557,
        64'hC000_0000_0000_0003,
        64'hD555_5555_5555_5557,
        64'hD5FF_5555_5555_FF57,
        64'hD555_5555_5555_5557,
        64'hD55F_F500_005F_F557,
        64'hD555_5555_5555_5557,
        64'hD5FF_5555_5555_FF57,
        64'hE555_5555_5555_555B,
        64'hD555_5555_5555_5557,
        64'hFFFF_FFFF_FFFF_FFFF
    };

    // Counts edible tiles among the first ncols columns of a layout row.
    function automatic int count_pellets_row(input maze_row_t row, input int ncols);
        int n;
        n = 0;
        for (int c = 0; c < MAZE_COLS; c++) begin
            if (c < ncols && (row[c] == PELLET || row[c] == POWER)) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/maze_reload_fsm.sv
// Reload sequencer: walks the rows once per reload, owns busy and the pellet count.
// The count accumulates per loaded row and is decremented by the top on each eat.
module maze_reload_fsm
    import maze_pkg::*;
#(
    parameter int ROWS  = MAZE_ROWS,
    parameter int COLS  = MAZE_COLS,
    parameter int CNT_W = $clog2(ROWS*COLS+1),
    localparam int RW   = $clog2(ROWS)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reload_start,
    input  logic             dec,
    output logic             busy,
    output logic             load_en,
    output logic [RW-1:0]    load_row,
    output logic [CNT_W-1:0] pellet_count
);

    typedef enum logic {RELOAD, RUN} state_t;

    state_t           state_reg;
    logic [RW-1:0]    row_reg;
    logic             busy_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] row_count;

    // Rows beyond the layout extent load as walls and carry no pellets.
    assign row_count = (int'(row_reg) < MAZE_ROWS)
                     ? CNT_W'(count_pellets_row(MAZE_INIT[row_reg], COLS))
                     : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RELOAD;
            row_reg   <= '0;
            busy_reg  <= 1'b1;
            count_reg <= '0;
        end else if (reload_start) begin
            state_reg <= RELOAD;
            row_reg   <= '0;
            busy_reg  <= 1'b1;
            count_reg <= '0;
        end else begin
            case (state_reg)
                RELOAD: begin
                    count_reg <= count_reg + row_count;
                    if (row_reg == RW'(ROWS-1)) begin
                        state_reg <= RUN;
                        row_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        row_reg <= row_reg + RW'(1);
                    end
                end
                RUN: begin
                    if (dec && count_reg != '0) begin
                        count_reg <= count_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= RELOAD;
            endcase
        end
    end

    assign busy         = busy_reg;
    assign load_en      = busy_reg;
    assign load_row     = row_reg;
    assign pellet_count = count_reg;

endmodule

// File: rtl/maze_tile_map.sv
// Writable maze tile store with NUM_RD read channels, an eat port and level reload.
// Optional frightened-mode timer is compiled in with `define MAZE_FRIGHT_TIMER_EN.
module maze_tile_map
    import maze_pkg::*;
#(
    parameter int ROWS          = MAZE_ROWS,
    parameter int COLS          = MAZE_COLS,
    parameter int NUM_RD        = 2,
    parameter int FRIGHT_CYCLES = 1000,
    localparam int RW           = $clog2(ROWS),
    localparam int CW           = $clog2(COLS),
    localparam int CNT_W        = $clog2(ROWS*COLS+1)
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD-1:0][RW-1:0]    rd_row,
    input  logic [NUM_RD-1:0][CW-1:0]    rd_col,
    output logic [NUM_RD-1:0][1:0]       rd_tile,
    input  logic                         eat_valid,
    input  logic [RW-1:0]                eat_row,
    input  logic [CW-1:0]                eat_col,
    output logic                         eat_pellet,
    output logic                         eat_power,
    input  logic                         reload_start,
    output logic                         busy,
    output logic [CNT_W-1:0]             pellet_count,
    output logic                         level_clear,
    output logic                         fright_active
);

    logic [1:0]            mem_reg [ROWS][COLS];
    logic                  load_en;
    logic [RW-1:0]         load_row;
    logic [COLS-1:0][1:0]  init_row;
    logic                  eat_in_range;
    logic [1:0]            eat_tile;
    logic                  eat_hit;
    logic                  eat_pellet_reg;
    logic                  eat_power_reg;
    logic                  level_clear_reg;

    maze_reload_fsm #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .CNT_W (CNT_W)
    ) u_reload (
        .clk          (clk),
        .rst_n        (rst_n),
        .reload_start (reload_start),
        .dec          (eat_hit),
        .busy         (busy),
        .load_en      (load_en),
        .load_row     (load_row),
        .pellet_count (pellet_count)
    );

    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_init
            if (gi < MAZE_COLS) begin : g_in
                assign init_row[gi] = (int'(load_row) < MAZE_ROWS) ? MAZE_INIT[load_row][gi] : WALL;
            end else begin : g_out
                assign init_row[gi] = WALL;
            end
        end
    endgenerate

    assign eat_in_range = (int'(eat_row) < ROWS) && (int'(eat_col) < COLS);
    assign eat_tile     = eat_in_range ? mem_reg[eat_row][eat_col] : WALL;
    // Reload has priority over a coincident eat.
    assign eat_hit      = eat_valid && !busy && !reload_start
                       && (eat_tile == PELLET || eat_tile == POWER);

    always_ff @(posedge clk) begin
        if (load_en) begin
            for (int c = 0; c < COLS; c++) begin
                mem_reg[load_row][c] <= init_row[c];
            end
        end else if (eat_hit) begin
            mem_reg[eat_row][eat_col] <= EMPTY;
        end
    end

    // Registered reads sample storage before a same-cycle eat write lands.
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic       rd_ok;
            logic [1:0] tile_reg;

            assign rd_ok = (int'(rd_row[gi]) < ROWS) && (int'(rd_col[gi]) < COLS);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tile_reg <= WALL;
                end else if (busy || !rd_ok) begin
                    tile_reg <= WALL;
                end else begin
                    tile_reg <= mem_reg[rd_row[gi]][rd_col[gi]];
                end
            end

            assign rd_tile[gi] = tile_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eat_pellet_reg  <= 1'b0;
            eat_power_reg   <= 1'b0;
            level_clear_reg <= 1'b0;
        end else begin
            eat_pellet_reg  <= eat_hit && (eat_tile == PELLET);
            eat_power_reg   <= eat_hit && (eat_tile == POWER);
            level_clear_reg <= !reload_start && !busy && (pellet_count == '0);
        end
    end

    assign eat_pellet  = eat_pellet_reg;
    assign eat_power   = eat_power_reg;
    assign level_clear = level_clear_reg;

`ifdef MAZE_FRIGHT_TIMER_EN
    localparam int FW = $clog2(FRIGHT_CYCLES+1);

    logic [FW-1:0] fright_reg;

    // Loads on the same edge the power pulse is launched; a new power pellet restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fright_reg <= '0;
        end else if (reload_start || busy) begin
            fright_reg <= '0;
        end else if (eat_hit && eat_tile == POWER) begin
            fright_reg <= FW'(FRIGHT_CYCLES);
        end else if (fright_reg != '0) begin
            fright_reg <= fright_reg - FW'(1);
        end
    end

    assign fright_active = (fright_reg != '0);
`else
    assign fright_active = 1'b0 & (FRIGHT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_maze_tile_map.sv
// Self-checking bench for maze_tile_map: table reads, hand sequences and random traffic
// compared every cycle against a cell-array model of the tile map.
module tb_maze_tile_map;
    import maze_pkg::*;

    localparam int ROWS = 24, COLS = 32, NUM_RD = 2, FR = 8;
    localparam int RW = 5, CW = 5, CNT_W = 10;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_RD-1:0][RW-1:0] rd_row;
    logic [NUM_RD-1:0][CW-1:0] rd_col;
    logic [NUM_RD-1:0][1:0]    rd_tile;
    logic                      eat_valid;
    logic [RW-1:0]             eat_row;
    logic [CW-1:0]             eat_col;
    logic                      eat_pellet, eat_power;
    logic                      reload_start;
    logic                      busy;
    logic [CNT_W-1:0]          pellet_count;
    logic                      level_clear, fright_active;

    maze_tile_map #(
        .ROWS(ROWS), .COLS(COLS), .NUM_RD(NUM_RD), .FRIGHT_CYCLES(FR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_row(rd_row), .rd_col(rd_col), .rd_tile(rd_tile),
        .eat_valid(eat_valid), .eat_row(eat_row), .eat_col(eat_col),
        .eat_pellet(eat_pellet), .eat_power(eat_power),
        .reload_start(reload_start), .busy(busy),
        .pellet_count(pellet_count), .level_clear(level_clear),
        .fright_active(fright_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: tile array plus reload progress in rows.
    int tile_m [ROWS][COLS];
    int row_total [ROWS];
    int total;
    int k_m;
    int count_m;
    int fright_m;

    task automatic restore();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                tile_m[r][c] = int'(MAZE_INIT[r][c]);
    endtask

    task automatic model_reset();
        k_m = 0;
        count_m = 0;
        fright_m = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int r0, input int c0, input int r1, input int c1,
                        input bit ev, input int er, input int ec, input bit rl);
        int  rr [2];
        int  cc [2];
        int  exp_rd [2];
        bit  busy_m, hit, lc_exp;
        int  et, pre_cnt;
        rr[0] = r0; rr[1] = r1; cc[0] = c0; cc[1] = c1;
        for (int i = 0; i < 2; i++) begin
            rd_row[i] = RW'(rr[i]);
            rd_col[i] = CW'(cc[i]);
        end
        eat_valid = ev; eat_row = RW'(er); eat_col = CW'(ec); reload_start = rl;

        busy_m = (k_m < ROWS);
        for (int i = 0; i < 2; i++)
            exp_rd[i] = (busy_m || rr[i] >= ROWS || cc[i] >= COLS) ? 3 : tile_m[rr[i]][cc[i]];
        et     = (er < ROWS && ec < COLS) ? tile_m[er][ec] : 3;
        hit    = ev && !busy_m && !rl && (et == 1 || et == 2);
        lc_exp = !rl && !busy_m && (count_m == 0);
        pre_cnt = int'(pellet_count);

        if (rl) begin
            model_reset();
        end else if (busy_m) begin
            count_m += row_total[k_m];
            k_m++;
            fright_m = 0;
            if (k_m == ROWS) restore();
        end else begin
            if (hit) begin
                tile_m[er][ec] = 0;
                count_m--;
            end
            if (hit && et == 2) fright_m = FR;
            else if (fright_m > 0) fright_m--;
        end

        tick();
        check("rd_tile0", rd_tile[0], exp_rd[0]);
        check("rd_tile1", rd_tile[1], exp_rd[1]);
        check("eat_pellet", eat_pellet, int'(hit && et == 1));
        check("eat_power", eat_power, int'(hit && et == 2));
        check("busy", busy, int'(k_m < ROWS));
        check("pellet_count", pellet_count, count_m);
        check("level_clear", level_clear, int'(lc_exp));
`ifdef MAZE_FRIGHT_TIMER_EN
        check("fright_active", fright_active, int'(fright_m > 0));
`else
        check("fright_active", fright_active, 0);
`endif
        if (hit) check("no_underflow", int'(pre_cnt > 0), 1);
        $display("t=%0t rd=(%0d,%0d)->%0d (%0d,%0d)->%0d eat=%0d@(%0d,%0d) rl=%0d | pel=%0d pow=%0d busy=%0d cnt=%0d lc=%0d fr=%0d",
                 $time, r0, c0, rd_tile[0], r1, c1, rd_tile[1], ev, er, ec, rl,
                 eat_pellet, eat_power, busy, pellet_count, level_clear, fright_active);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rd0"}, rd_tile[0], 3);
        check({tag, "_rd1"}, rd_tile[1], 3);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_cnt"}, pellet_count, 0);
        check({tag, "_pel"}, eat_pellet, 0);
        check({tag, "_pow"}, eat_power, 0);
        check({tag, "_lc"}, level_clear, 0);
        check({tag, "_fr"}, fright_active, 0);
    endtask

    task automatic wait_reload(input string tag);
        int n;
        n = 0;
        do begin
            step(1, 1, 2, 1, 1'b0, 0, 0, 1'b0);
            n++;
        end while (busy && n < 100);
        check({tag, "_busy_len"}, n, 24);
        check({tag, "_count"}, pellet_count, total);
    endtask

    typedef struct {
        int r0, c0, r1, c1, e0, e1;
    } rd_vec_t;

    initial begin
        rd_vec_t tbl [5];
        int fcnt;
        int er, ec;

        rd_row = '0; rd_col = '0;
        eat_valid = 1'b0; eat_row = '0; eat_col = '0; reload_start = 1'b0;

        total = 0;
        for (int r = 0; r < ROWS; r++) begin
            row_total[r] = 0;
            for (int c = 0; c < COLS; c++)
                if (MAZE_INIT[r][c] == PELLET || MAZE_INIT[r][c] == POWER) row_total[r]++;
            total += row_total[r];
        end
        restore();
        model_reset();

        tbl[0] = '{r0: 1, c0: 1,  r1: 0,  c1: 0,  e0: 1, e1: 3};
        tbl[1] = '{r0: 2, c0: 1,  r1: 2,  c1: 30, e0: 2, e1: 2};
        tbl[2] = '{r0: 8, c0: 5,  r1: 24, c1: 3,  e0: 0, e1: 3};
        tbl[3] = '{r0: 1, c0: 31, r1: 31, c1: 31, e0: 3, e1: 3};
        tbl[4] = '{r0: 1, c0: 30, r1: 23, c1: 10, e0: 1, e1: 3};

        // Reset, then the initial reload.
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;
        wait_reload("init");

        foreach (tbl[i]) begin
            step(tbl[i].r0, tbl[i].c0, tbl[i].r1, tbl[i].c1, 1'b0, 0, 0, 1'b0);
            check("tbl_rd0", rd_tile[0], tbl[i].e0);
            check("tbl_rd1", rd_tile[1], tbl[i].e1);
        end

        // Eat a pellet, re-read it, eat it again.
        step(0, 0, 0, 0, 1'b1, 1, 5, 1'b0);
        check("eat1_pulse", eat_pellet, 1);
        check("eat1_count", pellet_count, total - 1);
        step(1, 5, 1, 5, 1'b0, 0, 0, 1'b0);
        check("eat1_reread", rd_tile[0], 0);
        step(0, 0, 0, 0, 1'b1, 1, 5, 1'b0);
        check("eat2_nopulse", eat_pellet, 0);
        check("eat2_count", pellet_count, total - 1);

        // Power pellet eaten and read in the same cycle.
        step(2, 1, 2, 1, 1'b1, 2, 1, 1'b0);
        check("pw_read", rd_tile[0], 2);
        check("pw_pulse", eat_power, 1);
        fcnt = int'(fright_active);
        repeat (12) begin
            idle();
            fcnt += int'(fright_active);
        end
`ifdef MAZE_FRIGHT_TIMER_EN
        check("fright_len", fcnt, FR);
`else
        check("fright_len", fcnt, 0);
`endif

        // Reload coincident with an eat: eat dropped, layout restored.
        step(0, 0, 0, 0, 1'b1, 1, 6, 1'b1);
        check("rl_eat_nopulse", eat_pellet, 0);
        wait_reload("rl_eat");
        step(1, 6, 1, 5, 1'b0, 0, 0, 1'b0);
        check("rl_restore_a", rd_tile[0], 1);
        check("rl_restore_b", rd_tile[1], 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31),
                 1'($urandom_range(0, 1)), $urandom_range(0, 25), $urandom_range(0, 31),
                 1'($urandom_range(0, 149) == 0));
        end
        while (k_m < ROWS) idle();

        // Reload restarted while busy, then reset mid-reload.
        step(0, 0, 0, 0, 1'b0, 0, 0, 1'b1);
        repeat (7) idle();
        step(0, 0, 0, 0, 1'b0, 0, 0, 1'b1);
        wait_reload("restart");
        step(0, 0, 0, 0, 1'b0, 0, 0, 1'b1);
        repeat (10) idle();
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        tick();
        check_reset("midrst_hold");
        rst_n = 1'b1;
        model_reset();
        wait_reload("midrst");

        // Eat every remaining edible tile.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (tile_m[r][c] == 1 || tile_m[r][c] == 2) begin
                    er = r; ec = c;
                    step(er, ec, 0, 0, 1'b1, er, ec, 1'b0);
                end
        check("all_eaten_count", pellet_count, 0);
        idle();
        check("level_clear_set", level_clear, 1);
        step(0, 0, 0, 0, 1'b0, 0, 0, 1'b1);
        check("level_clear_drop", level_clear, 0);
        wait_reload("final");
        check("final_lc", level_clear, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, passed %0d of %0d", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
